// File: rtl/fifo_split.sv
// Synchronous show-ahead FIFO that stores only the low and high fields of a
// packed word, with valid/ready on both sides, fill level, almost-full and sticky overflow.
module fifo_split #(
   parameter  int W_LO      = 128,
   parameter  int GAP       = 8,
   parameter  int W_HI      = 48,
   parameter  int DEPTH     = 4,
   parameter  int AF_THRESH = 3,
   localparam int W_IN      = W_HI + GAP + W_LO,
   localparam int LW        = $clog2(DEPTH) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [W_IN-1:0] data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [W_LO-1:0] data_lo_o,
   output logic [W_HI-1:0] data_hi_o,
   output logic [LW-1:0]   level_o,
   output logic            almost_full_o,
   output logic            ovf_o,
   input  logic            clr_ovf_i
);

   localparam int PW  = $clog2(DEPTH);
   localparam int W_E = W_HI + W_LO;

   logic [W_E-1:0] mem [DEPTH];
   logic [W_E-1:0] head;
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [LW-1:0]  count;
   logic [LW-1:0]  count_nxt;
   logic           push;
   logic           pop;
   logic           af_q;
   logic           ovf_q;

   // The gap field is deliberately discarded; reduce it so its bits count as consumed.
   generate
      if (GAP > 0) begin : g_gap
         logic gap_unused;
         assign gap_unused = ^data_i[W_LO +: GAP];
      end
   endgenerate

   // No pass-through when full: readiness depends on the stored count only.
   assign in_ready_o  = (count != LW'(DEPTH));
   assign out_valid_o = (count != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      // NOTE: default assignment first, so no path leaves count_nxt unassigned (no latch).
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + LW'(1);
      end else if (pop && !push) begin
         count_nxt = count - LW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments, so every register here sees pre-edge values.
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         af_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_nxt;
         af_q  <= (count_nxt >= LW'(AF_THRESH));
         // A fresh overflow attempt outranks a clear in the same cycle.
         if (in_valid_i && !in_ready_o) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
         end
      end
   end

   // NOTE: storage is not reset; emptiness is tracked by count, and outputs are masked.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         mem[wr_ptr] <= {data_i[W_IN-1 -: W_HI], data_i[W_LO-1:0]};
      end
   end

   assign head          = mem[rd_ptr];
   assign data_lo_o     = out_valid_o ? head[W_LO-1:0]   : '0;
   assign data_hi_o     = out_valid_o ? head[W_E-1:W_LO] : '0;
   assign level_o       = count;
   assign almost_full_o = af_q;
   assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_fifo_split.sv
// Self-checking bench for fifo_split: directed scenarios plus a randomized run
// scored against a queue-based model of the FIFO behaviour.
module tb_fifo_split;

   localparam int W_LO  = 128;
   localparam int GAP   = 8;
   localparam int W_HI  = 48;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
   localparam int W_IN  = W_HI + GAP + W_LO;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int W_E   = W_HI + W_LO;

   typedef logic [W_E-1:0]  entry_t;
   typedef logic [W_IN-1:0] word_t;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [W_IN-1:0] data_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [W_LO-1:0] data_lo_o;
   logic [W_HI-1:0] data_hi_o;
   logic [LW-1:0]   level_o;
   logic            almost_full_o;
   logic            ovf_o;
   logic            clr_ovf_i;

   fifo_split #(
      .W_LO(W_LO), .GAP(GAP), .W_HI(W_HI), .DEPTH(DEPTH), .AF_THRESH(AF)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_i(data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .data_lo_o(data_lo_o), .data_hi_o(data_hi_o),
      .level_o(level_o), .almost_full_o(almost_full_o),
      .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i)
   );

   always #5 clk_i = ~clk_i;

   entry_t mq[$];
   bit     m_ovf;
   int     checks;
   int     errors;

   function automatic entry_t pack(input word_t d);
      return {d[W_IN-1 -: W_HI], d[W_LO-1:0]};
   endfunction

   function automatic word_t rand_word();
      return W_IN'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   function automatic word_t count_word(input int k);
      return {48'(k) ^ 48'hF00D_0000_0000, 8'hA5, 128'(k) + 128'h5A00_0000_0000_0000_0000_0000_0000_0000};
   endfunction

   // Drive one cycle of inputs, clock it, and advance the model by the same rules.
   task automatic step(input logic vld, input word_t d, input logic rdy,
                       input logic clr, input logic rst);
      int n;
      in_valid_i  = vld;
      data_i      = d;
      out_ready_i = rdy;
      clr_ovf_i   = clr;
      rst_i       = rst;
      @(posedge clk_i);
      n = mq.size();
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         if (n != 0 && rdy) void'(mq.pop_front());
         if (vld && n != DEPTH) mq.push_back(pack(d));
         if (vld && n == DEPTH) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, rand_word(), 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready_o); end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid_o); end
      checks++; if (data_lo_o !== '0) begin errors++; $display("FAIL reset_data_lo got %h exp 0", data_lo_o); end
      checks++; if (data_hi_o !== '0) begin errors++; $display("FAIL reset_data_hi got %h exp 0", data_hi_o); end
      checks++; if (level_o !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_o); end
      checks++; if (almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full_o); end
      checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
   endtask

   task automatic test_single();
      word_t w;
      w = {48'hABCDEF012345, 8'hFF, 128'h0123456789ABCDEF0123456789ABCDEF};
      step(1'b1, w, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid_o); end
      checks++; if (data_hi_o !== 48'hABCDEF012345) begin errors++; $display("FAIL single_hi got %h exp abcdef012345", data_hi_o); end
      checks++; if (data_lo_o !== 128'h0123456789ABCDEF0123456789ABCDEF) begin errors++; $display("FAIL single_lo got %h exp 0123456789abcdef0123456789abcdef", data_lo_o); end
      checks++; if (level_o !== LW'(1)) begin errors++; $display("FAIL single_level got %0d exp 1", level_o); end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid_o !== 1'b0 || data_lo_o !== '0 || data_hi_o !== '0) begin
         errors++; $display("FAIL single_drained got valid=%b lo=%h hi=%h exp 0", out_valid_o, data_lo_o, data_hi_o);
      end
   endtask

   task automatic test_fill_overflow();
      word_t w[DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         w[i] = rand_word();
         step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
         checks++; if (level_o !== LW'(i + 1)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level_o, i + 1); end
         checks++; if (almost_full_o !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_af got %b exp %b at level %0d", almost_full_o, (i + 1 >= AF), i + 1); end
      end
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready_o); end
      step(1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_o); end
      checks++; if (level_o !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level got %0d exp %0d", level_o, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if ({data_hi_o, data_lo_o} !== pack(w[i])) begin
            errors++; $display("FAIL drain_order[%0d] got %h exp %h", i, {data_hi_o, data_lo_o}, pack(w[i]));
         end
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid_o); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf_o); end
   endtask

   task automatic test_stream();
      step(1'b1, count_word(0), 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < 20; k++) begin
         checks++; if ({data_hi_o, data_lo_o} !== pack(count_word(k - 1)) || out_valid_o !== 1'b1) begin
            errors++; $display("FAIL stream_data[%0d] got %h exp %h", k - 1, {data_hi_o, data_lo_o}, pack(count_word(k - 1)));
         end
         checks++; if (level_o !== LW'(1)) begin errors++; $display("FAIL stream_level got %0d exp 1", level_o); end
         step(1'b1, count_word(k), 1'b1, 1'b0, 1'b0);
      end
      checks++; if ({data_hi_o, data_lo_o} !== pack(count_word(19))) begin
         errors++; $display("FAIL stream_last got %h exp %h", {data_hi_o, data_lo_o}, pack(count_word(19)));
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (level_o !== '0) begin errors++; $display("FAIL stream_end_level got %0d exp 0", level_o); end
   endtask

   task automatic test_full_pushpop();
      word_t w[DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         w[i] = rand_word();
         step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, rand_word(), 1'b1, 1'b0, 1'b0);
      checks++; if (level_o !== LW'(DEPTH - 1)) begin errors++; $display("FAIL fullpp_level got %0d exp %0d", level_o, DEPTH - 1); end
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL fullpp_ovf got %b exp 1", ovf_o); end
      checks++; if ({data_hi_o, data_lo_o} !== pack(w[1])) begin
         errors++; $display("FAIL fullpp_head got %h exp %h", {data_hi_o, data_lo_o}, pack(w[1]));
      end
      // Same-cycle overflow attempt and clear: the set must win.
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, w[0], 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_word(), 1'b0, 1'b1, 1'b0);
      checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf_o); end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear_only got %b exp 0", ovf_o); end
   endtask

   task automatic test_mid_reset();
      word_t w;
      // FIFO is full from the previous scenario: overflow, then pop to level 3.
      step(1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (level_o !== LW'(3) || ovf_o !== 1'b1) begin
         errors++; $display("FAIL prereset got level=%0d ovf=%b exp level=3 ovf=1", level_o, ovf_o);
      end
      step(1'b1, rand_word(), 1'b1, 1'b0, 1'b1);
      checks++; if (level_o !== '0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || ovf_o !== 1'b0) begin
         errors++; $display("FAIL midreset_ctrl got level=%0d valid=%b ready=%b ovf=%b exp 0 0 1 0", level_o, out_valid_o, in_ready_o, ovf_o);
      end
      checks++; if (data_lo_o !== '0 || data_hi_o !== '0) begin
         errors++; $display("FAIL midreset_data got lo=%h hi=%h exp 0", data_lo_o, data_hi_o);
      end
      w = rand_word();
      step(1'b1, w, 1'b0, 1'b0, 1'b0);
      checks++; if ({data_hi_o, data_lo_o} !== pack(w) || level_o !== LW'(1)) begin
         errors++; $display("FAIL postreset_push got %h level=%0d exp %h level=1", {data_hi_o, data_lo_o}, level_o, pack(w));
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      entry_t exp_head;
      int     n;
      for (int c = 0; c < 600; c++) begin
         n = mq.size();
         exp_head = (n != 0) ? mq[0] : '0;
         checks++; if (in_ready_o !== (n != DEPTH) || out_valid_o !== (n != 0)) begin
            errors++; $display("FAIL rand_hs[%0d] got ready=%b valid=%b exp %b %b", c, in_ready_o, out_valid_o, (n != DEPTH), (n != 0));
         end
         checks++; if ({data_hi_o, data_lo_o} !== exp_head) begin
            errors++; $display("FAIL rand_data[%0d] got %h exp %h", c, {data_hi_o, data_lo_o}, exp_head);
         end
         checks++; if (level_o !== LW'(n) || almost_full_o !== (n >= AF) || ovf_o !== m_ovf) begin
            errors++; $display("FAIL rand_status[%0d] got level=%0d af=%b ovf=%b exp %0d %b %b", c, level_o, almost_full_o, ovf_o, n, (n >= AF), m_ovf);
         end
         step($urandom_range(0, 99) < 60, rand_word(), $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      m_ovf  = 1'b0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_stream();
      test_full_pushpop();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
